pmp_seq_check: RTL and testbench

PMP_SEQ_CHECK -- requirements
Module: pmp_seq_check

---
 rtl/pmp_seq_check_pkg.sv | 57 +++++
 rtl/pmp_seq_check_entry.sv | 36 +++
 rtl/pmp_seq_check.sv | 164 ++++++++++++++++
 tb/tb_pmp_seq_check.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_seq_check_pkg.sv
// Shared types for the sequential PMP checker: core configuration, PMP
// configuration fields, privilege/access encodings, FSM state and helpers.
package pmp_seq_check_pkg;

  typedef struct packed {
    int unsigned NrPMPEntries;
    int unsigned PLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrPMPEntries: 8, PLEN: 34};

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_t;

  typedef enum logic [2:0] {
    ACCESS_NONE  = 3'b000,
    ACCESS_READ  = 3'b001,
    ACCESS_WRITE = 3'b010,
    ACCESS_EXEC  = 3'b100
  } pmp_access_t;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;

  // Check sequencer states; exposed on the debug port of the top.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_RESP = 2'b10
  } scan_state_e;

  // Number of scan groups needed to cover n entries, d entries at a time.
  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/pmp_seq_check_entry.sv
// Address matcher for one PMP entry (OFF/TOR/NA4/NAPOT); purely combinational.
module pmp_seq_check_entry
  import pmp_seq_check_pkg::*;
#(
  parameter int unsigned Plen = 34
) (
  input  logic [Plen-1:0] addr_i,
  input  logic [Plen-3:0] conf_addr_i,
  input  logic [Plen-3:0] conf_addr_prev_i,
  input  pmp_addr_mode_t  addr_mode_i,
  output logic            match_o
);

  logic [Plen-3:0] w_word;
  logic [Plen-3:0] w_napot_mask;
  logic            w_unused_lsb;

  // pmpaddr registers hold address bits [Plen-1:2]; byte offset never matters.
  assign w_word       = addr_i[Plen-1:2];
  assign w_unused_lsb = ^addr_i[1:0];
  // Trailing ones plus the first zero of pmpaddr give the NAPOT don't-care bits.
  assign w_napot_mask = conf_addr_i ^ (conf_addr_i + 1'b1);

  // Select the match rule for the entry's address mode.
  always_comb begin
    match_o = 1'b0;
    unique case (addr_mode_i)
      PMP_OFF:   match_o = 1'b0;
      PMP_TOR:   match_o = (w_word >= conf_addr_prev_i) && (w_word < conf_addr_i);
      PMP_NA4:   match_o = (w_word == conf_addr_i);
      PMP_NAPOT: match_o = ((w_word & ~w_napot_mask) == (conf_addr_i & ~w_napot_mask));
      default:   match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pmp_seq_check.sv
// Sequential PMP checker: scans EntriesPerCycle entries per cycle, lowest
// applicable matching entry wins. Handshakes: a request transfers on a cycle
// where req_valid_i && req_ready_o; a response transfers on a cycle where
// resp_valid_o && resp_ready_i, and the response outputs hold stable until then.
module pmp_seq_check
  import pmp_seq_check_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg         = cva6_cfg_empty,
  parameter int unsigned EntriesPerCycle = 4,
  localparam int unsigned NrEntries = CVA6Cfg.NrPMPEntries,
  localparam int unsigned Plen      = CVA6Cfg.PLEN,
  localparam int unsigned NrArr     = (NrEntries > 0) ? NrEntries : 1,
  localparam int unsigned IdxW      = $clog2((NrEntries > 2) ? NrEntries : 2)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [Plen-1:0] addr_i,
  input  pmp_access_t     access_type_i,
  input  priv_lvl_t       priv_lvl_i,
  input  logic [Plen-3:0] conf_addr_i [NrArr],
  input  pmpcfg_t         conf_i [NrArr],
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic            allow_o,
  output logic            hit_o,
  output logic [IdxW-1:0] hit_idx_o,
  output scan_state_e     dbg_state_o
);

  localparam int unsigned E        = EntriesPerCycle;
  localparam int unsigned NrGroups = ceil_div(NrEntries, E);
  localparam int unsigned LastGrp  = (NrGroups > 0) ? NrGroups - 1 : 0;
  localparam int unsigned CntW     = $clog2(NrGroups) + 1;

  scan_state_e     r_state, w_state_nxt;
  logic [Plen-1:0] r_addr;
  pmp_access_t     r_access;
  priv_lvl_t       r_priv;
  logic [CntW-1:0] r_grp;
  logic            r_allow, r_hit;
  logic [IdxW-1:0] r_hit_idx;

  logic            w_lane_vld   [E];
  logic [IdxW-1:0] w_lane_idx   [E];
  pmpcfg_t         w_lane_cfg   [E];
  logic [Plen-3:0] w_lane_addr  [E];
  logic [Plen-3:0] w_lane_prev  [E];
  logic            w_lane_match [E];
  logic            w_unused_rsvd;
  logic            w_win, w_win_allow, w_last_grp, w_nohit_allow;
  logic [IdxW-1:0] w_win_idx;

  // Route the current group's entries (and TOR lower bounds) onto the lanes.
  always_comb begin
    int unsigned base;
    int unsigned idx;
    base          = 32'(r_grp) * E;
    w_unused_rsvd = 1'b0;
    for (int k = 0; k < int'(E); k++) begin
      idx            = base + k;
      w_lane_vld[k]  = (idx < NrEntries);
      w_lane_idx[k]  = w_lane_vld[k] ? IdxW'(idx) : '0;
      w_lane_cfg[k]  = conf_i[w_lane_idx[k]];
      w_lane_addr[k] = conf_addr_i[w_lane_idx[k]];
      w_lane_prev[k] = (w_lane_idx[k] == '0) ? '0 : conf_addr_i[w_lane_idx[k] - 1'b1];
      w_unused_rsvd  = w_unused_rsvd ^ (^w_lane_cfg[k].reserved);
    end
  end

  for (genvar k = 0; k < int'(E); k++) begin : g_lane
    pmp_seq_check_entry #(.Plen(Plen)) u_entry (
      .addr_i          (r_addr),
      .conf_addr_i     (w_lane_addr[k]),
      .conf_addr_prev_i(w_lane_prev[k]),
      .addr_mode_i     (w_lane_cfg[k].addr_mode),
      .match_o         (w_lane_match[k])
    );
  end

  // Priority pick: walk lanes high to low so the lowest index is kept last.
  always_comb begin
    w_win       = 1'b0;
    w_win_idx   = '0;
    w_win_allow = 1'b0;
    for (int k = int'(E) - 1; k >= 0; k--) begin
      if (w_lane_vld[k] && w_lane_match[k] &&
          ((r_priv != PRIV_LVL_M) || w_lane_cfg[k].locked)) begin
        w_win       = 1'b1;
        w_win_idx   = w_lane_idx[k];
        w_win_allow = ((3'(r_access) & 3'(w_lane_cfg[k].access_type)) == 3'(r_access));
      end
    end
  end

  assign w_last_grp    = (r_grp == CntW'(LastGrp));
  // With no PMP entries implemented, every access is permitted.
  assign w_nohit_allow = (NrEntries == 0) ? 1'b1 : (r_priv == PRIV_LVL_M);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; flush outranks completion and response acceptance.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (req_valid_i) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (flush_i)                  w_state_nxt = ST_IDLE;
        else if (w_win || w_last_grp) w_state_nxt = ST_RESP;
      end
      ST_RESP: if (flush_i || resp_ready_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, group counter and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr    <= '0;
      r_access  <= ACCESS_NONE;
      r_priv    <= PRIV_LVL_U;
      r_grp     <= '0;
      r_allow   <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else if (r_state == ST_IDLE) begin
      if (req_valid_i) begin
        r_addr   <= addr_i;
        r_access <= access_type_i;
        r_priv   <= priv_lvl_i;
        r_grp    <= '0;
      end
    end else if (r_state == ST_SCAN && !flush_i) begin
      if (w_win) begin
        r_hit     <= 1'b1;
        r_hit_idx <= w_win_idx;
        r_allow   <= w_win_allow;
      end else if (w_last_grp) begin
        r_hit     <= 1'b0;
        r_hit_idx <= '0;
        r_allow   <= w_nohit_allow;
      end else begin
        r_grp <= r_grp + 1'b1;
      end
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    req_ready_o  = (r_state == ST_IDLE);
    resp_valid_o = (r_state == ST_RESP);
    allow_o      = r_allow;
    hit_o        = r_hit;
    hit_idx_o    = r_hit_idx;
    dbg_state_o  = r_state;
  end

endmodule

// File: tb/tb_pmp_seq_check.sv
// Directed bench for pmp_seq_check: N=8 entries, 4 entries per scan cycle.
module tb_pmp_seq_check;
  import pmp_seq_check_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [33:0] addr = '0;
  pmp_access_t access = ACCESS_NONE;
  priv_lvl_t   priv = PRIV_LVL_U;
  logic [31:0] conf_addr [8];
  pmpcfg_t     conf [8];
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        allow, hit;
  logic [2:0]  hit_idx;
  scan_state_e dbg_state;

  pmp_seq_check #(.CVA6Cfg(cva6_cfg_empty), .EntriesPerCycle(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .addr_i       (addr),
    .access_type_i(access),
    .priv_lvl_i   (priv),
    .conf_addr_i  (conf_addr),
    .conf_i       (conf),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .allow_o      (allow),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .dbg_state_o  (dbg_state)
  );

  typedef struct {
    int          sel;
    priv_lvl_t   p;
    pmp_access_t a;
    logic [33:0] ad;
    logic        e_allow;
    logic        e_hit;
    logic [2:0]  e_idx;
    int          e_lat;
  } vec_t;

  vec_t vecs [15];
  int   n_checks = 0;
  int   n_fail = 0;

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic pmpcfg_t mk_cfg(input logic l, input pmp_addr_mode_t m, input logic [2:0] xwr);
    pmpcfg_t c;
    c             = '0;
    c.locked      = l;
    c.addr_mode   = m;
    c.access_type = pmpcfg_access_t'(xwr);
    return c;
  endfunction

  // PMP configurations used by the vectors.
  task automatic set_scenario(input int sel);
    for (int i = 0; i < 8; i++) begin
      conf_addr[i] = '0;
      conf[i]      = mk_cfg(1'b0, PMP_OFF, 3'b000);
    end
    case (sel)
      0: begin  // entry 5: NAPOT 4 KiB @ 0x8000_0000, R only
        conf_addr[5] = 32'h2000_01FF; conf[5] = mk_cfg(1'b0, PMP_NAPOT, 3'b001);
      end
      1: begin  // as 0, plus entry 1 locked over the same region, no permissions
        conf_addr[5] = 32'h2000_01FF; conf[5] = mk_cfg(1'b0, PMP_NAPOT, 3'b001);
        conf_addr[1] = 32'h2000_01FF; conf[1] = mk_cfg(1'b1, PMP_NAPOT, 3'b000);
      end
      2: begin  // entry 0: TOR [0,0x1000) RWX; entry 2: NA4 @ 0x800 R
        conf_addr[0] = 32'h0000_0400; conf[0] = mk_cfg(1'b0, PMP_TOR, 3'b111);
        conf_addr[2] = 32'h0000_0200; conf[2] = mk_cfg(1'b0, PMP_NA4, 3'b001);
      end
      3: begin  // entry 4: TOR [0x9000_0000,0x9000_1000) RW, bound from entry 3
        conf_addr[3] = 32'h2400_0000; conf[3] = mk_cfg(1'b0, PMP_OFF, 3'b111);
        conf_addr[4] = 32'h2400_0400; conf[4] = mk_cfg(1'b0, PMP_TOR, 3'b011);
      end
      default: ;
    endcase
  endtask

  // Driver: one request handshake, optionally with flush asserted in IDLE.
  task automatic issue(input int sel, input priv_lvl_t p, input pmp_access_t a,
                       input logic [33:0] ad, input logic fl);
    set_scenario(sel);
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; priv = p; access = a; addr = ad; flush = fl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_timeout", 64'(resp_valid), 64'd1);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{0, PRIV_LVL_U, ACCESS_READ,  34'h0_8000_0010, 1'b1, 1'b1, 3'd5, 2};
    vecs[1]  = '{0, PRIV_LVL_U, ACCESS_WRITE, 34'h0_8000_0010, 1'b0, 1'b1, 3'd5, 2};
    vecs[2]  = '{0, PRIV_LVL_M, ACCESS_READ,  34'h0_8000_0010, 1'b1, 1'b0, 3'd0, 2};
    vecs[3]  = '{4, PRIV_LVL_M, ACCESS_EXEC,  34'h0_1234_5678, 1'b1, 1'b0, 3'd0, 2};
    vecs[4]  = '{1, PRIV_LVL_M, ACCESS_READ,  34'h0_8000_0010, 1'b0, 1'b1, 3'd1, 1};
    vecs[5]  = '{2, PRIV_LVL_U, ACCESS_READ,  34'h0_0000_0800, 1'b1, 1'b1, 3'd0, 1};
    vecs[6]  = '{2, PRIV_LVL_U, ACCESS_EXEC,  34'h0_0000_0800, 1'b1, 1'b1, 3'd0, 1};
    vecs[7]  = '{3, PRIV_LVL_U, ACCESS_WRITE, 34'h0_9000_0800, 1'b1, 1'b1, 3'd4, 2};
    vecs[8]  = '{3, PRIV_LVL_U, ACCESS_WRITE, 34'h0_9000_1000, 1'b0, 1'b0, 3'd0, 2};
    vecs[9]  = '{3, PRIV_LVL_U, ACCESS_READ,  34'h0_9000_0000, 1'b1, 1'b1, 3'd4, 2};
    vecs[10] = '{3, PRIV_LVL_U, ACCESS_EXEC,  34'h0_9000_0004, 1'b0, 1'b1, 3'd4, 2};
    vecs[11] = '{0, PRIV_LVL_U, ACCESS_READ,  34'h0_8000_1000, 1'b0, 1'b0, 3'd0, 2};
    vecs[12] = '{0, PRIV_LVL_S, ACCESS_READ,  34'h0_8000_0FFC, 1'b1, 1'b1, 3'd5, 2};
    vecs[13] = '{2, PRIV_LVL_U, ACCESS_WRITE, 34'h0_0000_0FFC, 1'b1, 1'b1, 3'd0, 1};
    vecs[14] = '{2, PRIV_LVL_U, ACCESS_READ,  34'h0_0000_1000, 1'b0, 1'b0, 3'd0, 2};
    set_scenario(4);

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_req_ready",  64'(req_ready),  64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_allow",      64'(allow),      64'd0);
    check("rst_hit",        64'(hit),        64'd0);
    check("rst_hit_idx",    64'(hit_idx),    64'd0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].sel, vecs[i].p, vecs[i].a, vecs[i].ad, 1'b0);
      wait_resp(lat);
      check($sformatf("v%0d_latency", i), 64'(lat),     64'(vecs[i].e_lat));
      check($sformatf("v%0d_allow", i),   64'(allow),   64'(vecs[i].e_allow));
      check($sformatf("v%0d_hit", i),     64'(hit),     64'(vecs[i].e_hit));
      check($sformatf("v%0d_idx", i),     64'(hit_idx), 64'(vecs[i].e_idx));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_resp_drop", i), 64'(resp_valid), 64'd0);
    end

    // Back-pressure: response held stable for 3 cycles
    resp_ready = 1'b0;
    issue(0, PRIV_LVL_U, ACCESS_READ, 34'h0_8000_0010, 1'b0);
    wait_resp(lat);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_valid", c),     64'(resp_valid), 64'd1);
      check($sformatf("stall%0d_allow", c),     64'(allow),      64'd1);
      check($sformatf("stall%0d_hit", c),       64'(hit),        64'd1);
      check($sformatf("stall%0d_idx", c),       64'(hit_idx),    64'd5);
      check($sformatf("stall%0d_req_ready", c), 64'(req_ready),  64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_ready", 64'(req_ready),  64'd1);
    check("stall_release_valid", 64'(resp_valid), 64'd0);

    // Flush during SCAN: no response, IDLE next cycle
    issue(0, PRIV_LVL_U, ACCESS_READ, 34'h0_8000_0010, 1'b0);
    check("flush_scan_state", 64'(dbg_state), 64'(ST_SCAN));
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_scan_ready", 64'(req_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("flush_scan_noresp%0d", c), 64'(resp_valid), 64'd0);
      @(posedge clk);
      #1;
    end

    // Flush in RESP wins over a stalled consumer
    resp_ready = 1'b0;
    issue(2, PRIV_LVL_U, ACCESS_READ, 34'h0_0000_0800, 1'b0);
    wait_resp(lat);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_resp_valid", 64'(resp_valid), 64'd0);
    check("flush_resp_ready", 64'(req_ready),  64'd1);
    resp_ready = 1'b1;

    // Flush in IDLE does not block the handshake
    issue(2, PRIV_LVL_U, ACCESS_READ, 34'h0_0000_0800, 1'b1);
    wait_resp(lat);
    check("flush_idle_latency", 64'(lat),     64'd1);
    check("flush_idle_idx",     64'(hit_idx), 64'd0);
    check("flush_idle_hit",     64'(hit),     64'd1);
    @(posedge clk);
    #1;

    // Reset asserted mid-SCAN discards the check
    issue(0, PRIV_LVL_U, ACCESS_READ, 34'h0_8000_0010, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_scan_req_ready",  64'(req_ready),  64'd1);
    check("rst_scan_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_scan_allow",      64'(allow),      64'd0);
    check("rst_scan_hit",        64'(hit),        64'd0);
    check("rst_scan_hit_idx",    64'(hit_idx),    64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_scan_hold_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_scan_after_ready", 64'(req_ready),  64'd1);
    check("rst_scan_after_valid", 64'(resp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
